// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a byte FIFO.
//
// Software writes bytes to DATA. They are queued in a FIFO and sent LSB
// first on uart_tx. STATUS reports the FIFO and line state. Read data is
// registered, so it appears one cycle after the address, like synchronous RAM.
//
// Ports:
//   clock               single clock
//   reset               synchronous, active-high
//   memory_addr         bus address; DATA = BASE_ADDR, STATUS = BASE_ADDR+1
//   memory_write_enable write strobe
//   memory_in           write data; bits [7:0] are the byte pushed on a DATA write
//   memory_out          registered read data (STATUS word or 0)
//   selected            combinational decode hit for the DATA or STATUS address
//   uart_tx             serial output, idle high
//
// STATUS word: [0] full, [1] empty, [2] busy, [7:3] count, [8] overflow
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | line high, waiting for the FIFO to become non-empty
// S_START | start bit (low) for CLOCK_DIV cycles
// S_DATA  | 8 data bits, LSB first, CLOCK_DIV cycles each
// S_STOP  | stop bit (high); on its last cycle, chain straight into the next frame
module uart_tx_mmio #(
    parameter int                   ADDR_SIZE       = 18,
    parameter int                   WORD_SIZE       = 18,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR       = 18'h3FF00,
    parameter int                   CLOCK_DIV       = 16,
    parameter int                   FIFO_DEPTH_LOG2 = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] memory_addr,
    input  logic                 memory_write_enable,
    input  logic [WORD_SIZE-1:0] memory_in,
    output logic [WORD_SIZE-1:0] memory_out,
    output logic                 selected,
    output logic                 uart_tx
);

    localparam int PTR_W = FIFO_DEPTH_LOG2;
    localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int DIV_W = $clog2(CLOCK_DIV);
    localparam logic [DIV_W-1:0]     DIV_RELOAD  = DIV_W'(CLOCK_DIV - 1);
    localparam logic [CNT_W-1:0]     CNT_FULL    = CNT_W'(DEPTH);
    localparam logic [ADDR_SIZE-1:0] STATUS_ADDR = BASE_ADDR + ADDR_SIZE'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [WORD_SIZE-1:0]   rdata_q, rdata_d;
    logic [7:0]             fifo_mem [DEPTH];

    logic                   hit_data, hit_status;
    logic                   fifo_full, fifo_empty;
    logic                   wr_data, push, pop, status_rd;
    logic [7:0]             fifo_head;
    logic [WORD_SIZE-1:0]   status;
    logic                   unused_bits;

    assign hit_data    = (memory_addr == BASE_ADDR);
    assign hit_status  = (memory_addr == STATUS_ADDR);
    assign selected    = hit_data | hit_status;
    assign fifo_full   = (count_q == CNT_FULL);
    assign fifo_empty  = (count_q == '0);
    assign wr_data     = memory_write_enable & hit_data;
    // Fullness uses the pre-edge count, so a push is refused even if a pop
    // lands on the same edge.
    assign push        = wr_data & ~fifo_full;
    assign status_rd   = hit_status & ~memory_write_enable;
    assign fifo_head   = fifo_mem[rd_ptr_q];
    assign unused_bits = ^memory_in[WORD_SIZE-1:8];

    assign memory_out  = rdata_q;
    assign uart_tx     = tx_q;

    always_comb begin
        status      = '0;
        status[0]   = fifo_full;
        status[1]   = fifo_empty;
        status[2]   = (state_q != S_IDLE);
        status[7:3] = 5'(count_q);
        status[8]   = overflow_q;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Read-clear returns the old value this cycle; a drop always re-sets it.
        overflow_d = overflow_q;
        if (status_rd)
            overflow_d = 1'b0;
        if (wr_data && fifo_full)
            overflow_d = 1'b1;
        rdata_d = hit_status ? status : '0;
    end

    // tx_d is the line level for the cycle after the edge, so every state
    // change also sets the bit that goes out with it.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    bit_d   = '0;
                    div_d   = DIV_RELOAD;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (div_q == '0) begin
                    div_d   = DIV_RELOAD;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            S_DATA: begin
                if (div_q == '0) begin
                    div_d = DIV_RELOAD;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            S_STOP: begin
                if (div_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        bit_d   = '0;
                        div_d   = DIV_RELOAD;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rdata_q    <= rdata_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push && !reset)
            fifo_mem[wr_ptr_q] <= memory_in[7:0];
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio (CLOCK_DIV=4, FIFO depth 4). A line/FIFO timeline
// model predicts each accepted byte's frame start, from which the expected
// line level, FIFO count and busy flag at any cycle follow.
module tb_uart_tx_mmio;

    localparam int CLOCK_DIV = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME     = 10 * CLOCK_DIV;
    localparam logic [17:0] BASE = 18'h3FF00;
    localparam logic [17:0] STAT = 18'h3FF01;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] memory_addr = '0;
    logic        memory_write_enable = 1'b0;
    logic [17:0] memory_in = '0;
    logic [17:0] memory_out;
    logic        selected;
    logic        uart_tx;

    uart_tx_mmio #(
        .ADDR_SIZE(18), .WORD_SIZE(18), .BASE_ADDR(BASE),
        .CLOCK_DIV(CLOCK_DIV), .FIFO_DEPTH_LOG2(2)
    ) dut (
        .clock(clock), .reset(reset), .memory_addr(memory_addr),
        .memory_write_enable(memory_write_enable), .memory_in(memory_in),
        .memory_out(memory_out), .selected(selected), .uart_tx(uart_tx)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { logic [7:0] data; int push; int start; } frame_t;
    frame_t frames[$];
    int     last_end = 0;
    logic   m_ovf = 1'b0;

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    int   mon_prints = 0;

    // A byte sits in the FIFO from the cycle after its push through the cycle
    // before its start bit (the pop cycle).
    function automatic int m_count(int t);
        int n = 0;
        foreach (frames[i])
            if (frames[i].push < t && frames[i].start - 1 >= t) n++;
        return n;
    endfunction

    function automatic logic m_busy(int t);
        foreach (frames[i])
            if (t >= frames[i].start && t < frames[i].start + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_tx(int t);
        int k;
        foreach (frames[i]) begin
            if (t >= frames[i].start && t < frames[i].start + FRAME) begin
                k = (t - frames[i].start) / CLOCK_DIV;
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return frames[i].data[k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [17:0] m_status(int t);
        int n;
        logic [17:0] s;
        n = m_count(t);
        s = '0;
        s[0]   = (n == DEPTH);
        s[1]   = (n == 0);
        s[2]   = m_busy(t);
        s[7:3] = 5'(n);
        s[8]   = m_ovf;
        return s;
    endfunction

    task automatic model_clear();
        frames.delete();
        last_end = 0;
        m_ovf = 1'b0;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            checks++;
            if (uart_tx !== m_tx(cyc)) begin
                errors++;
                if (mon_prints < 20)
                    $display("FAIL line_model cycle %0d: uart_tx=%b expected %b", cyc, uart_tx, m_tx(cyc));
                mon_prints++;
            end
        end
    end

    task automatic bus_idle();
        memory_addr = 18'h00000;
        memory_write_enable = 1'b0;
        memory_in = '0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic bus_write(input logic [17:0] a, input logic [17:0] d);
        int st;
        memory_addr = a;
        memory_write_enable = 1'b1;
        memory_in = d;
        if (a == BASE) begin
            if (m_count(cyc) >= DEPTH) m_ovf = 1'b1;
            else begin
                st = (cyc + 2 > last_end) ? cyc + 2 : last_end;
                frames.push_back('{data: d[7:0], push: cyc, start: st});
                last_end = st + FRAME;
            end
        end
        @(negedge clock);
        bus_idle();
    endtask

    task automatic bus_read(input logic [17:0] a, output logic [17:0] got, output logic [17:0] want);
        memory_addr = a;
        memory_write_enable = 1'b0;
        want = (a == STAT) ? m_status(cyc) : 18'h0;
        if (a == STAT) m_ovf = 1'b0;
        @(negedge clock);
        got = memory_out;
        bus_idle();
    endtask

    task automatic test_reset();
        logic [17:0] got, want, a;
        logic [17:0] a_tab [4];
        logic        s_tab [4];
        logic        exp_sel;
        a_tab = '{BASE, STAT, BASE + 18'd2, BASE - 18'd1};
        s_tab = '{1'b1, 1'b1, 1'b0, 1'b0};
        reset = 1'b1;
        bus_idle();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        model_clear();
        mon_en = 1'b1;
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
        checks++;
        if (memory_out !== 18'h0) begin errors++; $display("FAIL reset_memout: got %h expected 0", memory_out); end
        bus_read(STAT, got, want);
        checks++;
        if (got !== 18'h002) begin errors++; $display("FAIL reset_status: got %h expected 002", got); end
        bus_read(18'h00123, got, want);
        checks++;
        if (got !== 18'h0) begin errors++; $display("FAIL unselected_read: got %h expected 0", got); end
        bus_read(STAT, got, want);
        bus_read(BASE, got, want);
        checks++;
        if (got !== 18'h0) begin errors++; $display("FAIL data_read: got %h expected 0", got); end
        for (int i = 0; i < 12; i++) begin
            if (i < 4) begin a = a_tab[i]; exp_sel = s_tab[i]; end
            else begin a = 18'($urandom); exp_sel = (a == BASE) || (a == STAT); end
            memory_addr = a;
            #1;
            checks++;
            if (selected !== exp_sel) begin
                errors++;
                $display("FAIL selected addr %h: got %b expected %b", a, selected, exp_sel);
            end
        end
        bus_idle();
        @(negedge clock);
    endtask

    task automatic test_single();
        logic [17:0] got, want;
        logic [9:0]  pat;
        logic [9:0]  up;
        int n;
        wait_until(last_end + 2);
        pat = {1'b1, 8'hA5, 1'b0};
        up = 10'($urandom);
        n = cyc;
        bus_write(BASE, {up, 8'hA5});
        bus_read(STAT, got, want);
        checks++;
        if (got !== 18'h008) begin errors++; $display("FAIL single_count1: got %h expected 008", got); end
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (uart_tx !== pat[k / CLOCK_DIV]) begin
                errors++;
                $display("FAIL single_frame cycle N+%0d: got %b expected %b", k + 2, uart_tx, pat[k / CLOCK_DIV]);
            end
            @(negedge clock);
        end
        checks++;
        if (cyc !== n + 2 + FRAME) begin errors++; $display("FAIL single_timing: cycle %0d expected %0d", cyc, n + 2 + FRAME); end
        bus_read(STAT, got, want);
        checks++;
        if (got !== 18'h002) begin errors++; $display("FAIL single_status_after: got %h expected 002", got); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] got, want;
        int w;
        wait_until(last_end + 2);
        w = cyc;
        bus_write(BASE, {10'h0, 8'h55});
        bus_write(BASE, {10'h0, 8'hAA});
        wait_until(w + 22);
        bus_read(STAT, got, want);
        checks++;
        if (got !== 18'h00C) begin errors++; $display("FAIL b2b_status_mid: got %h expected 00c", got); end
        checks++;
        if (got !== want) begin errors++; $display("FAIL b2b_status_model: got %h expected %h", got, want); end
        wait_until(w + 41);
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL b2b_last_stop: got %b expected 1", uart_tx); end
        @(negedge clock);
        checks++;
        if (uart_tx !== 1'b0) begin errors++; $display("FAIL b2b_no_gap: got %b expected 0", uart_tx); end
        wait_until(w + 82);
        bus_read(STAT, got, want);
        checks++;
        if (got !== 18'h002) begin errors++; $display("FAIL b2b_busy_drop: got %h expected 002", got); end
    endtask

    task automatic test_overflow();
        logic [17:0] got, want;
        wait_until(last_end + 2);
        for (int i = 0; i < 6; i++) bus_write(BASE, 18'($urandom));
        bus_write(STAT, 18'($urandom));
        bus_write(BASE + 18'd2, 18'($urandom));
        bus_write(BASE - 18'd1, 18'($urandom));
        bus_read(STAT, got, want);
        checks++;
        if (got !== 18'h125) begin errors++; $display("FAIL ovf_status: got %h expected 125", got); end
        checks++;
        if (got !== want) begin errors++; $display("FAIL ovf_status_model: got %h expected %h", got, want); end
        bus_read(STAT, got, want);
        checks++;
        if (got[8] !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", got[8]); end
        checks++;
        if (got !== want) begin errors++; $display("FAIL ovf_second_model: got %h expected %h", got, want); end
        wait_until(last_end + 2);
        bus_read(STAT, got, want);
        checks++;
        if (got !== 18'h002) begin errors++; $display("FAIL ovf_drain: got %h expected 002", got); end
    endtask

    task automatic test_push_pop();
        logic [17:0] got, want;
        int w;
        wait_until(last_end + 2);
        w = cyc;
        bus_write(BASE, 18'($urandom));
        bus_write(BASE, 18'($urandom));
        wait_until(w + 41);
        bus_write(BASE, 18'($urandom));
        bus_read(STAT, got, want);
        checks++;
        if (got[7:3] !== 5'd1) begin errors++; $display("FAIL pushpop_count: got %0d expected 1", got[7:3]); end
        checks++;
        if (got !== want) begin errors++; $display("FAIL pushpop_status: got %h expected %h", got, want); end
        wait_until(last_end + 2);
        bus_read(STAT, got, want);
        checks++;
        if (got !== 18'h002) begin errors++; $display("FAIL pushpop_drain: got %h expected 002", got); end
    endtask

    task automatic test_reset_mid();
        logic [17:0] got, want;
        int w, rr, lows;
        wait_until(last_end + 2);
        w = cyc;
        bus_write(BASE, 18'($urandom));
        bus_write(BASE, 18'($urandom));
        rr = w + 6 + $urandom_range(0, 31);
        wait_until(rr);
        mon_en = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b expected 1", uart_tx); end
        mon_en = 1'b1;
        bus_read(STAT, got, want);
        checks++;
        if (got !== 18'h002) begin errors++; $display("FAIL midreset_status: got %h expected 002", got); end
        lows = 0;
        repeat (60) begin
            @(negedge clock);
            if (uart_tx !== 1'b1) lows++;
        end
        checks++;
        if (lows !== 0) begin errors++; $display("FAIL midreset_quiet: got %0d low cycles expected 0", lows); end
    endtask

    task automatic test_random();
        logic [17:0] got, want;
        int r;
        for (int it = 0; it < 50; it++) begin
            r = $urandom_range(0, 9);
            if (r < 5) bus_write(BASE, 18'($urandom));
            else if (r < 7) begin
                bus_read(STAT, got, want);
                checks++;
                if (got !== want) begin errors++; $display("FAIL rand_status it %0d: got %h expected %h", it, got, want); end
            end else if (r < 8) begin
                bus_read(BASE, got, want);
                checks++;
                if (got !== 18'h0) begin errors++; $display("FAIL rand_data_read it %0d: got %h expected 0", it, got); end
            end else begin
                repeat ($urandom_range(1, 30)) @(negedge clock);
            end
        end
        wait_until(last_end + 2);
        bus_read(STAT, got, want);
        checks++;
        if (got !== want) begin errors++; $display("FAIL rand_final: got %h expected %h", got, want); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_pop();
        test_reset_mid();
        test_random();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
